// File: rtl/vmul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// vmul_issue_ctrl
//
// Issue controller for one vector multiply instruction. A command (beat count,
// SEW, opSel, widen, base line address) is accepted while idle. Operand beats
// are then taken from the operand-fetch stream and forwarded to the
// multiplier, one per cycle, with line addresses counting up from the base.
// The multiplier has a fixed latency and no stall input. To make sure no
// result is ever dropped, issue is gated by a credit counter that mirrors the
// free result-buffer slots. A count of in-flight beats decides when every
// result has returned, and done pulses at that point.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready while idle)
//   cmd_len/sew/opsel/widen  command fields; len is the number of beats, 0 legal
//   cmd_addr                 base destination line address
//   op_valid/op_ready        operand beat handshake
//   op_vec0, op_vec1         operand beat
//   mul_valid, mul_*         registered issue towards the multiplier inputs
//   mul_out_valid            multiplier result strobe (in-flight return)
//   res_pop                  result buffer freed one slot (credit return)
//   busy                     controller not idle
//   done                     one-cycle completion pulse
//   err                      sticky: a result returned with nothing in flight
// ---------------------------------------------------------------------------
module vmul_issue_ctrl #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int SEW_WIDTH      = 2,
    parameter int OPSEL_WIDTH    = 2,
    parameter int LEN_WIDTH      = 8,
    parameter int MUL_LATENCY    = 6,
    parameter int RES_CREDITS    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic [SEW_WIDTH-1:0]      cmd_sew,
    input  logic [OPSEL_WIDTH-1:0]    cmd_opsel,
    input  logic                      cmd_widen,
    input  logic [REQ_ADDR_WIDTH-1:0] cmd_addr,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [REQ_DATA_WIDTH-1:0] op_vec0,
    input  logic [REQ_DATA_WIDTH-1:0] op_vec1,
    output logic                      mul_valid,
    output logic [REQ_DATA_WIDTH-1:0] mul_vec0,
    output logic [REQ_DATA_WIDTH-1:0] mul_vec1,
    output logic [SEW_WIDTH-1:0]      mul_sew,
    output logic [OPSEL_WIDTH-1:0]    mul_opsel,
    output logic                      mul_widen,
    output logic [REQ_ADDR_WIDTH-1:0] mul_addr,
    input  logic                      mul_out_valid,
    input  logic                      res_pop,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int CRED_W = $clog2(RES_CREDITS + 1);
    localparam int INFL_W = $clog2(MUL_LATENCY + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(RES_CREDITS);

    logic [1:0]                state;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      beat_idx;
    logic [REQ_ADDR_WIDTH-1:0] base_q;
    logic [SEW_WIDTH-1:0]      sew_q;
    logic [OPSEL_WIDTH-1:0]    opsel_q;
    logic                      widen_q;
    logic [CRED_W-1:0]         credits;
    logic [INFL_W-1:0]         inflight;
    logic [INFL_W-1:0]         inflight_nxt;

    logic cmd_acc;
    logic hs_p0;
    logic last_beat;
    logic spurious;

    assign cmd_ready = (state == S_IDLE);
    assign op_ready  = (state == S_ISSUE) && (credits != '0);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    assign cmd_acc   = cmd_valid && cmd_ready;
    assign hs_p0     = op_valid && op_ready;
    // len_q is non-zero whenever we are in ISSUE, so len_q-1 never wraps here.
    assign last_beat = (beat_idx == (len_q - LEN_WIDTH'(1)));
    // A result with nothing issued and nothing counted cannot belong to us.
    assign spurious  = mul_out_valid && !mul_valid && (inflight == '0);

    // Next in-flight count: an issue and a return in the same cycle cancel.
    // A stray return at zero is flagged through err instead of underflowing.
    always_comb begin
        inflight_nxt = inflight;
        case ({mul_valid, mul_out_valid})
            2'b10:   inflight_nxt = inflight + INFL_W'(1);
            2'b01:   if (inflight != '0) inflight_nxt = inflight - INFL_W'(1);
            default: inflight_nxt = inflight;
        endcase
    end

    // Control: state, beat index, credits, in-flight count, err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            beat_idx <= '0;
            credits  <= CRED_FULL;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            inflight <= inflight_nxt;

            // Credits persist across commands; a pop that would overflow is dropped.
            case ({hs_p0, res_pop})
                2'b10:   credits <= credits - CRED_W'(1);
                2'b01:   if (credits < CRED_FULL) credits <= credits + CRED_W'(1);
                default: credits <= credits;
            endcase

            if (cmd_acc)
                err <= 1'b0;
            else if (spurious)
                err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cmd_acc) begin
                        beat_idx <= '0;
                        state    <= (cmd_len != '0) ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (hs_p0) begin
                        beat_idx <= beat_idx + LEN_WIDTH'(1);
                        if (last_beat)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (inflight_nxt == '0)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Command fields captured on accept; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (cmd_acc) begin
            len_q   <= cmd_len;
            base_q  <= cmd_addr;
            sew_q   <= cmd_sew;
            opsel_q <= cmd_opsel;
            widen_q <= cmd_widen;
        end
    end

    // ---- stage p0 -> p1: operand handshake registered into multiplier issue ----
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_valid <= 1'b0;
            mul_vec0  <= '0;
            mul_vec1  <= '0;
            mul_sew   <= '0;
            mul_opsel <= '0;
            mul_widen <= 1'b0;
            mul_addr  <= '0;
        end else begin
            mul_valid <= hs_p0;
            if (hs_p0) begin
                mul_vec0  <= op_vec0;
                mul_vec1  <= op_vec1;
                mul_sew   <= sew_q;
                mul_opsel <= opsel_q;
                mul_widen <= widen_q;
                mul_addr  <= base_q + REQ_ADDR_WIDTH'(beat_idx);
            end
        end
    end

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
module tb_vmul_issue_ctrl;

    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int LAT = 6;
    localparam int CRD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [7:0]    cmd_len;
    logic [1:0]    cmd_sew, cmd_opsel;
    logic          cmd_widen;
    logic [AW-1:0] cmd_addr;
    logic          op_valid, op_ready;
    logic [DW-1:0] op_vec0, op_vec1;
    logic          mul_valid;
    logic [DW-1:0] mul_vec0, mul_vec1;
    logic [1:0]    mul_sew, mul_opsel;
    logic          mul_widen;
    logic [AW-1:0] mul_addr;
    logic          mul_out_valid;
    logic          res_pop;
    logic          busy, done, err;
    logic          spur;

    vmul_issue_ctrl #(
        .REQ_DATA_WIDTH(DW), .REQ_ADDR_WIDTH(AW), .SEW_WIDTH(2), .OPSEL_WIDTH(2),
        .LEN_WIDTH(8), .MUL_LATENCY(LAT), .RES_CREDITS(CRD)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_sew(cmd_sew), .cmd_opsel(cmd_opsel), .cmd_widen(cmd_widen), .cmd_addr(cmd_addr),
        .op_valid(op_valid), .op_ready(op_ready), .op_vec0(op_vec0), .op_vec1(op_vec1),
        .mul_valid(mul_valid), .mul_vec0(mul_vec0), .mul_vec1(mul_vec1),
        .mul_sew(mul_sew), .mul_opsel(mul_opsel), .mul_widen(mul_widen), .mul_addr(mul_addr),
        .mul_out_valid(mul_out_valid), .res_pop(res_pop),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Fixed-latency multiplier stand-in; flushed by reset with the controller.
    logic [LAT-1:0] pipe;
    always @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[LAT-2:0], mul_valid};
    end
    assign mul_out_valid = pipe[LAT-1] | spur;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] v0;
        logic [DW-1:0] v1;
        logic [4:0]    ctl;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [7:0]    len;
        logic [AW-1:0] addr;
        logic [1:0]    sew;
        logic [1:0]    opsel;
        logic          widen;
        int            lat;
        logic [AW-1:0] last;
    } vec_t;
    vec_t vt[5];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, acc_cyc = 0;
    int nbeats, hs_cnt, opr_cnt, done_cnt, first_mv, done_cyc;
    logic [63:0]   mv_hist, hs_hist;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] exp_base;
    int            exp_idx;
    logic [4:0]    exp_ctl;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic mon();
        sb_t e;
        int  d;
        d = cyc - acc_cyc;
        if (mul_valid) begin
            chk("mul_valid_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("mul_addr", 128'(mul_addr), 128'(e.addr));
                chk("mul_vec", {mul_vec0, mul_vec1}, {e.v0, e.v1});
                chk("mul_ctl", 128'({mul_sew, mul_opsel, mul_widen}), 128'(e.ctl));
            end
            nbeats++;
            last_addr = mul_addr;
            if (first_mv < 0) first_mv = d;
            if (d >= 0 && d < 64) mv_hist[d] = 1'b1;
        end else if (sb.size() != 0) begin
            chk("mul_valid_missing", 128'(mul_valid), 128'(1));
            sb.delete();
        end
        if (op_ready) opr_cnt++;
        if (op_valid && op_ready) begin
            e.addr = exp_base + AW'(exp_idx);
            e.v0   = op_vec0;
            e.v1   = op_vec1;
            e.ctl  = exp_ctl;
            sb.push_back(e);
            exp_idx++;
            hs_cnt++;
            if (d >= 0 && d < 64) hs_hist[d] = 1'b1;
        end
        if (done) begin
            done_cnt++;
            done_cyc = d;
        end
        if (rst) sb.delete();
    endtask

    task automatic half();
        @(negedge clk);
        mon();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_vec();
        op_vec0 = {$urandom, $urandom};
        op_vec1 = {$urandom, $urandom};
    endtask

    task automatic clear_stats();
        nbeats = 0; hs_cnt = 0; opr_cnt = 0; done_cnt = 0;
        first_mv = -1; done_cyc = -1; mv_hist = '0; hs_hist = '0; last_addr = '0;
    endtask

    task automatic start_cmd(input logic [7:0] len, input logic [AW-1:0] addr,
                             input logic [1:0] sew, input logic [1:0] opsel, input logic widen,
                             input logic exp_err0);
        clear_stats();
        exp_base  = addr;
        exp_idx   = 0;
        exp_ctl   = {sew, opsel, widen};
        acc_cyc   = cyc;
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_addr  = addr;
        cmd_sew   = sew;
        cmd_opsel = opsel;
        cmd_widen = widen;
        op_valid  = 1'b0;
        half();
        chk("accept_ready", 128'(cmd_ready), 128'(1));
        chk("accept_busy", 128'(busy), 128'(0));
        chk("accept_err", 128'(err), 128'(exp_err0));
        adv();
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] len, input logic [AW-1:0] addr,
                           input logic [1:0] sew, input logic [1:0] opsel, input logic widen,
                           input logic [63:0] ov_mask, input int pop_start, input logic exp_err0);
        int k;
        res_pop = (pop_start <= 0);
        start_cmd(len, addr, sew, opsel, widen, exp_err0);
        k = 1;
        while (done_cnt == 0 && k < 400) begin
            op_valid = (k < 64) ? ov_mask[k] : 1'b1;
            res_pop  = (k >= pop_start);
            drive_vec();
            half();
            adv();
            k++;
        end
        op_valid = 1'b0;
        chk("beats_issued", 128'(nbeats), 128'(len));
        chk("handshakes", 128'(hs_cnt), 128'(len));
        chk("done_pulses", 128'(done_cnt), 128'(1));
        chk("done_deasserted", 128'(done), 128'(0));
        chk("err_after", 128'(err), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        vt[0] = '{len: 8'd4, addr: 32'h0000_0100, sew: 2'd1, opsel: 2'd2, widen: 1'b0, lat: 12, last: 32'h0000_0103};
        vt[1] = '{len: 8'd0, addr: 32'h0000_0200, sew: 2'd3, opsel: 2'd1, widen: 1'b1, lat: 1,  last: 32'h0000_0000};
        vt[2] = '{len: 8'd3, addr: 32'hFFFF_FFFE, sew: 2'd2, opsel: 2'd0, widen: 1'b1, lat: 11, last: 32'h0000_0000};
        vt[3] = '{len: 8'd1, addr: 32'h0000_1234, sew: 2'd0, opsel: 2'd3, widen: 1'b0, lat: 9,  last: 32'h0000_1234};
        vt[4] = '{len: 8'd9, addr: 32'h7FFF_FFFC, sew: 2'd1, opsel: 2'd1, widen: 1'b1, lat: 17, last: 32'h8000_0004};

        rst = 1'b1; spur = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_addr = '0;
        cmd_sew = '0; cmd_opsel = '0; cmd_widen = 1'b0; op_valid = 1'b0;
        op_vec0 = '0; op_vec1 = '0; res_pop = 1'b0;
        exp_base = '0; exp_idx = 0; exp_ctl = '0;
        clear_stats();
        repeat (3) adv();
        rst = 1'b0;
        half();
        chk("rst_mul_valid", 128'(mul_valid), 128'(0));
        chk("rst_payload", {mul_vec0, mul_vec1}, 128'(0));
        chk("rst_addr_ctl", 128'({mul_addr, mul_sew, mul_opsel, mul_widen}), 128'(0));
        chk("rst_flags", 128'({cmd_ready, busy, done, err, op_ready}), 128'(5'b10000));
        adv();

        // Table of commands, operands always offered, results popped every cycle.
        for (int i = 0; i < 5; i++) begin
            run_cmd(vt[i].len, vt[i].addr, vt[i].sew, vt[i].opsel, vt[i].widen, '1, 0, 1'b0);
            chk("done_latency", 128'(done_cyc), 128'(vt[i].lat));
            chk("op_ready_cycles", 128'(opr_cnt), 128'(vt[i].len));
            if (vt[i].len != 0) begin
                chk("last_addr", 128'(last_addr), 128'(vt[i].last));
                chk("first_mul_valid", 128'(first_mv), 128'(2));
            end
        end

        // Operand bubbles: op_valid 1,0,1,0,1 from the first issue cycle.
        run_cmd(8'd3, 32'h0000_0A00, 2'd2, 2'd2, 1'b0, ~64'h14, 0, 1'b0);
        chk("bubble_pattern", 128'(mv_hist[6:2]), 128'(5'b10101));
        chk("bubble_done", 128'(done_cyc), 128'(13));
        chk("bubble_last_addr", 128'(last_addr), 128'(32'h0000_0A02));

        // Credit stall: no pops until 16 cycles after accept.
        run_cmd(8'd5, 32'h0000_0500, 2'd1, 2'd0, 1'b1, '1, 16, 1'b0);
        chk("stall_early_hs", 128'($countones(hs_hist[15:0])), 128'(2));
        chk("stall_late_hs", 128'(hs_hist[19:16]), 128'(4'b1110));
        chk("stall_op_ready", 128'(opr_cnt), 128'(5));
        chk("stall_done", 128'(done_cyc), 128'(27));

        // Spurious result while idle sets err until the next accept.
        spur = 1'b1;
        half();
        adv();
        spur = 1'b0;
        chk("err_set", 128'(err), 128'(1));
        repeat (3) begin half(); adv(); end
        chk("err_sticky", 128'(err), 128'(1));
        run_cmd(8'd2, 32'h0000_0600, 2'd3, 2'd3, 1'b1, '1, 0, 1'b1);
        chk("err_cmd_done", 128'(done_cyc), 128'(10));

        // Reset in DRAIN with results in flight and credits exhausted.
        res_pop = 1'b0;
        start_cmd(8'd2, 32'h0000_0300, 2'd0, 2'd1, 1'b0, 1'b0);
        op_valid = 1'b1;
        repeat (2) begin drive_vec(); half(); adv(); end
        op_valid = 1'b0;
        chk("pre_rst_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        half();
        adv();
        rst = 1'b0;
        chk("post_rst_mul_valid", 128'(mul_valid), 128'(0));
        chk("post_rst_payload", {mul_vec0, mul_vec1}, 128'(0));
        chk("post_rst_addr_ctl", 128'({mul_addr, mul_sew, mul_opsel, mul_widen}), 128'(0));
        chk("post_rst_flags", 128'({cmd_ready, busy, done, err}), 128'(4'b1000));
        run_cmd(8'd3, 32'h0000_0400, 2'd2, 2'd1, 1'b1, '1, 10, 1'b0);
        chk("post_rst_credits", 128'($countones(hs_hist[9:0])), 128'(2));
        chk("post_rst_done", 128'(done_cyc), 128'(19));
        chk("post_rst_err", 128'(err), 128'(0));

        half();
        chk("final_idle", 128'({cmd_ready, busy}), 128'(2'b10));
        adv();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
